// File: rtl/spi_ss_sequencer.sv
// Round-robin SPI slave-select sequencer: grants one client at a time, frames its burst
// with a chip-select, feeds words to an SPI master and holds ss_n high for a guard period.
module spi_ss_sequencer #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_SS  = 5,
  parameter int unsigned CMD_W   = 16,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned GUARD   = 2,
  localparam int unsigned SSW    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
  localparam int unsigned IDXW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned GW     = (GUARD > 1) ? $clog2(GUARD) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*SSW-1:0]   req_ss_i,
  input  logic [NUM_REQ*LEN_W-1:0] req_len_i,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       word_ack_o,
  output logic [CMD_W-1:0]         rd_data_o,
  output logic                     rd_valid_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     err_o,
  output logic                     spi_wrt_o,
  output logic [CMD_W-1:0]         spi_cmd_o,
  input  logic                     spi_done_i,
  input  logic [CMD_W-1:0]         spi_rdata_i,
  output logic [NUM_SS-1:0]        ss_n_o
);

  typedef enum logic [2:0] {StIdle, StAssert, StSend, StWait, StRelease} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDXW-1:0]      owner_q, owner_d;
  logic [IDXW-1:0]      ptr_q, ptr_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]        gcnt_q, gcnt_d;
  logic [NUM_SS-1:0]    ss_n_q, ss_n_d;
  logic [CMD_W-1:0]     spi_cmd_q, spi_cmd_d;
  logic [CMD_W-1:0]     rd_data_q, rd_data_d;
  logic                 spi_wrt_q, spi_wrt_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 err_q, err_d;
  logic [NUM_REQ-1:0]   word_ack_q, word_ack_d;
  logic [NUM_REQ-1:0]   done_q, done_d;

  logic [IDXW-1:0]      win;
  logic [SSW-1:0]       win_ss;
  logic [LEN_W-1:0]     win_len;
  logic [CMD_W-1:0]     cur_cmd;
  logic                 win_ss_bad;

  // Search starts at ptr_q and wraps, so the last granted client has lowest priority.
  always_comb begin
    int unsigned cand;
    logic        found;
    win   = ptr_q;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ptr_q + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found && req_i[IDXW'(cand)]) begin
        win   = IDXW'(cand);
        found = 1'b1;
      end
    end
  end

  assign win_ss     = req_ss_i[win*SSW +: SSW];
  assign win_len    = req_len_i[win*LEN_W +: LEN_W];
  assign cur_cmd    = req_cmd_i[owner_q*CMD_W +: CMD_W];
  assign win_ss_bad = 32'(win_ss) >= NUM_SS;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    gcnt_d     = gcnt_q;
    ss_n_d     = ss_n_q;
    spi_cmd_d  = spi_cmd_q;
    rd_data_d  = rd_data_q;
    spi_wrt_d  = 1'b0;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    word_ack_d = '0;
    done_d     = '0;

    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          gnt_d   = NUM_REQ'(1) << win;
          owner_d = win;
          cnt_d   = win_len;
          ptr_d   = (win == IDXW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          if (win_ss_bad) begin
            state_d = StRelease;
            gcnt_d  = '0;
            err_d   = 1'b1;
            done_d  = NUM_REQ'(1) << win;
          end else begin
            state_d = StAssert;
            ss_n_d  = '1;
            for (int unsigned j = 0; j < NUM_SS; j++) begin
              if (SSW'(j) == win_ss) begin
                ss_n_d[j] = 1'b0;
              end
            end
          end
        end
      end
      StAssert: begin
        state_d    = StSend;
        spi_wrt_d  = 1'b1;
        spi_cmd_d  = cur_cmd;
        word_ack_d = gnt_q;
      end
      StSend: begin
        state_d = StWait;
      end
      StWait: begin
        if (spi_done_i) begin
          rd_data_d  = spi_rdata_i;
          rd_valid_d = 1'b1;
          // cnt_q holds words remaining minus one, so zero means this was the last word.
          if (cnt_q == '0) begin
            state_d = StRelease;
            ss_n_d  = '1;
            gcnt_d  = '0;
            done_d  = gnt_q;
          end else begin
            cnt_d      = cnt_q - 1'b1;
            state_d    = StSend;
            spi_wrt_d  = 1'b1;
            spi_cmd_d  = cur_cmd;
            word_ack_d = gnt_q;
          end
        end
      end
      StRelease: begin
        if (gcnt_q == GW'(GUARD - 1)) begin
          state_d = StIdle;
          gnt_d   = '0;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      gcnt_q     <= '0;
      ss_n_q     <= '1;
      spi_cmd_q  <= '0;
      rd_data_q  <= '0;
      spi_wrt_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      word_ack_q <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      gcnt_q     <= gcnt_d;
      ss_n_q     <= ss_n_d;
      spi_cmd_q  <= spi_cmd_d;
      rd_data_q  <= rd_data_d;
      spi_wrt_q  <= spi_wrt_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      word_ack_q <= word_ack_d;
      done_q     <= done_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign word_ack_o = word_ack_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign spi_wrt_o  = spi_wrt_q;
  assign spi_cmd_o  = spi_cmd_q;
  assign ss_n_o     = ss_n_q;

endmodule

// File: tb/tb_spi_ss_sequencer.sv
// Bench for spi_ss_sequencer: client and SPI-master models drive the DUT while a scoreboard
// of expected grants, commands, read data and completions is popped as the DUT responds.
module tb_spi_ss_sequencer;

  localparam int unsigned NR  = 4;
  localparam int unsigned NS  = 5;
  localparam int unsigned CW  = 16;
  localparam int unsigned LW  = 4;
  localparam int unsigned SSW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*SSW-1:0] req_ss;
  logic [NR*LW-1:0]  req_len;
  logic [NR*CW-1:0]  req_cmd;
  logic [NR-1:0]     gnt, word_ack, done;
  logic [CW-1:0]     rd_data, spi_cmd, spi_rdata;
  logic              rd_valid, err, spi_wrt, spi_done;
  logic [NS-1:0]     ss_n;

  spi_ss_sequencer #(
    .NUM_REQ (NR),
    .NUM_SS  (NS),
    .CMD_W   (CW),
    .LEN_W   (LW),
    .GUARD   (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .req_ss_i    (req_ss),
    .req_len_i   (req_len),
    .req_cmd_i   (req_cmd),
    .gnt_o       (gnt),
    .word_ack_o  (word_ack),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .done_o      (done),
    .err_o       (err),
    .spi_wrt_o   (spi_wrt),
    .spi_cmd_o   (spi_cmd),
    .spi_done_i  (spi_done),
    .spi_rdata_i (spi_rdata),
    .ss_n_o      (ss_n)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [CW-1:0] base [NR];
  int            widx [NR];
  logic [CW-1:0] exp_cmd_q [$];
  logic [CW-1:0] exp_rd_q [$];
  int            exp_gnt_q [$];
  int            exp_done_q [$];  // bit 4 = err expected, bits 3:0 = client

  int            n_wrt, n_ack, n_done, n_lowcyc, n_low_edges, n_gnt_cyc, ss_bad, pend;
  logic [NR-1:0] prev_gnt = '0;
  logic          prev_ss_high;
  logic [CW-1:0] rnext, last_cmd;
  bit            have_cmd = 1'b0;

  task automatic set_client(input int i, input int ss, input int len, input logic [CW-1:0] b);
    req_ss[i*SSW +: SSW] = SSW'(ss);
    req_len[i*LW +: LW]  = LW'(len);
    base[i]              = b;
    widx[i]              = 0;
    req_cmd[i*CW +: CW]  = b;
  endtask

  task automatic push_txn(input int i, input int len, input bit is_err);
    exp_gnt_q.push_back(i);
    exp_done_q.push_back(i | (is_err ? 16 : 0));
    if (!is_err) begin
      for (int k = 0; k <= len; k++) begin
        exp_cmd_q.push_back(base[i] + CW'(k) * 16'h0101);
      end
    end
  endtask

  // Scoreboard sampling, called once per negedge while a transaction runs.
  task automatic sb_sample();
    int            e;
    logic [CW-1:0] ec;
    tests_run++;
    if ($countones(~ss_n) > 1) begin
      tests_failed++;
      $display("FAIL ss_n_onehot: got %b, want at most one low bit", ss_n);
    end
    if (gnt != '0) begin
      tests_run++;
      if (!$onehot(gnt)) begin
        tests_failed++;
        $display("FAIL gnt_onehot: got %b, want one-hot", gnt);
      end
    end
    if (prev_gnt == '0 && gnt != '0) begin
      tests_run++;
      if (exp_gnt_q.size() == 0) begin
        tests_failed++;
        $display("FAIL gnt_unexpected: got %b, want no grant", gnt);
      end else begin
        e = exp_gnt_q.pop_front();
        if (gnt !== 4'(1 << e)) begin
          tests_failed++;
          $display("FAIL gnt_order: got %b, want %b", gnt, 4'(1 << e));
        end
      end
    end
    prev_gnt = gnt;
    if (spi_wrt === 1'b1) begin
      tests_run++;
      if (exp_cmd_q.size() == 0) begin
        tests_failed++;
        $display("FAIL spi_wrt_extra: got spi_cmd %h, want no write", spi_cmd);
      end else begin
        ec = exp_cmd_q.pop_front();
        if (spi_cmd !== ec) begin
          tests_failed++;
          $display("FAIL spi_cmd: got %h, want %h", spi_cmd, ec);
        end
      end
      last_cmd = spi_cmd;
      have_cmd = 1'b1;
    end else if (have_cmd) begin
      tests_run++;
      if (spi_cmd !== last_cmd) begin
        tests_failed++;
        $display("FAIL spi_cmd_hold: got %h, want %h", spi_cmd, last_cmd);
      end
    end
    if (word_ack != '0) begin
      tests_run++;
      if (word_ack !== gnt) begin
        tests_failed++;
        $display("FAIL word_ack_owner: got %b, want %b", word_ack, gnt);
      end
    end
    if (rd_valid === 1'b1) begin
      tests_run++;
      if (exp_rd_q.size() == 0) begin
        tests_failed++;
        $display("FAIL rd_valid_extra: got rd_data %h, want no read", rd_data);
      end else begin
        ec = exp_rd_q.pop_front();
        if (rd_data !== ec) begin
          tests_failed++;
          $display("FAIL rd_data: got %h, want %h", rd_data, ec);
        end
      end
    end
    if (done != '0 || err === 1'b1) begin
      tests_run++;
      if (exp_done_q.size() == 0) begin
        tests_failed++;
        $display("FAIL done_extra: got done %b err %b, want none", done, err);
      end else begin
        e = exp_done_q.pop_front();
        if (done !== 4'(1 << (e & 15)) || err !== 1'(e >> 4)) begin
          tests_failed++;
          $display("FAIL done_err: got done %b err %b, want done %b err %b",
                   done, err, 4'(1 << (e & 15)), 1'(e >> 4));
        end
      end
    end
  endtask

  // Runs client + SPI master models until `target` done pulses and the DUT is idle again.
  // With abort_wrt > 0, asserts rst in the WAIT cycle following that spi_wrt and returns.
  task automatic run_txn(input int target, input bit drop_on_gnt, input logic [NS-1:0] exp_ss,
                         input int abort_wrt, input int lat_max, input int max_cycles);
    int dcount = 0;
    bit abort_next = 1'b0;
    bit fin = 1'b0;
    n_wrt = 0; n_ack = 0; n_done = 0; n_lowcyc = 0; n_low_edges = 0; n_gnt_cyc = 0;
    ss_bad = 0; pend = 0;
    prev_ss_high = (ss_n == '1);
    for (int c = 0; c < max_cycles && !fin; c++) begin
      @(negedge clk);
      if (abort_next) begin
        rst      = 1'b1;
        spi_done = 1'b0;
        fin      = 1'b1;
      end else begin
        sb_sample();
        if (spi_wrt) n_wrt++;
        if (word_ack != '0) n_ack++;
        if (done != '0) begin
          n_done++;
          dcount++;
        end
        if (gnt != '0) n_gnt_cyc++;
        if (ss_n != '1) begin
          n_lowcyc++;
          if (ss_n !== exp_ss) ss_bad++;
          if (prev_ss_high) n_low_edges++;
        end
        prev_ss_high = (ss_n == '1);
        if (abort_wrt > 0 && spi_wrt && n_wrt == abort_wrt) abort_next = 1'b1;
        for (int i = 0; i < int'(NR); i++) begin
          if (word_ack[i]) begin
            widx[i]++;
            req_cmd[i*CW +: CW] = base[i] + CW'(widx[i]) * 16'h0101;
          end
          if (done[i]) begin
            widx[i] = 0;
            req_cmd[i*CW +: CW] = base[i];
          end
        end
        if (drop_on_gnt && gnt != '0) req = req & ~gnt;
        if (dcount >= target) req = '0;
        spi_done = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            spi_done  = 1'b1;
            spi_rdata = rnext;
            exp_rd_q.push_back(rnext);
            rnext = rnext + 16'h0011;
          end
        end
        if (spi_wrt) pend = $urandom_range(lat_max, 1);
        if (abort_wrt == 0 && dcount >= target && gnt == '0 && pend == 0) fin = 1'b1;
      end
    end
    tests_run++;
    if (!fin) begin
      tests_failed++;
      $display("FAIL timeout: got no completion after %0d cycles, want completion", max_cycles);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests_run++;
    if (got != want) begin
      tests_failed++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_drained(input string name);
    tests_run++;
    if (exp_cmd_q.size() != 0 || exp_rd_q.size() != 0 || exp_gnt_q.size() != 0 ||
        exp_done_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drained: got cmd %0d rd %0d gnt %0d done %0d left, want 0", name,
               exp_cmd_q.size(), exp_rd_q.size(), exp_gnt_q.size(), exp_done_q.size());
    end
  endtask

  task automatic check_idle_outputs(input string name);
    tests_run++;
    if (ss_n !== 5'b11111 || gnt !== '0 || word_ack !== '0 || done !== '0 || err !== 1'b0 ||
        rd_valid !== 1'b0 || spi_wrt !== 1'b0 || spi_cmd !== '0 || rd_data !== '0) begin
      tests_failed++;
      $display("FAIL %s: got ss_n %b gnt %b ack %b done %b err %b rv %b wrt %b cmd %h rd %h, %s",
               name, ss_n, gnt, word_ack, done, err, rd_valid, spi_wrt, spi_cmd, rd_data,
               "want ss_n 11111 and all others 0");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_values");
    rst       = 1'b0;
    spi_done  = 1'b1;
    spi_rdata = 16'hDEAD;
    @(negedge clk);
    spi_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_idle_outputs("spi_done_after_reset");
      @(negedge clk);
    end
  endtask

  task automatic test_arbitration();
    int order [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < int'(NR); i++) set_client(i, i, 0, CW'((i + 1) * 16'h1000));
    for (int k = 0; k < 5; k++) push_txn(order[k], 0, 1'b0);
    rnext = 16'h0100;
    req   = 4'b1111;
    run_txn(5, 1'b0, 5'b00000, 0, 2, 200);
    check_int("arb_done_count", n_done, 5);
    check_int("arb_wrt_count", n_wrt, 5);
    check_drained("arb");
  endtask

  task automatic test_single();
    set_client(2, 1, 0, 16'hA5C3);
    push_txn(2, 0, 1'b0);
    rnext = 16'h00FF;
    req   = 4'b0100;
    run_txn(1, 1'b1, 5'b11101, 0, 1, 50);
    check_int("single_wrt_count", n_wrt, 1);
    check_int("single_ack_count", n_ack, 1);
    check_int("single_ss_low_cycles", n_lowcyc, 3);
    check_int("single_ss_value", ss_bad, 0);
    check_int("single_gnt_cycles", n_gnt_cyc, 5);
    check_int("single_done_count", n_done, 1);
    check_drained("single");
  endtask

  task automatic test_burst();
    set_client(0, 4, 2, 16'h1234);
    push_txn(0, 2, 1'b0);
    rnext = 16'h4000;
    req   = 4'b0001;
    run_txn(1, 1'b1, 5'b01111, 0, 3, 200);
    check_int("burst_wrt_count", n_wrt, 3);
    check_int("burst_ack_count", n_ack, 3);
    check_int("burst_ss_low_edges", n_low_edges, 1);
    check_int("burst_ss_value", ss_bad, 0);
    check_int("burst_done_count", n_done, 1);
    check_drained("burst");
  endtask

  task automatic test_invalid_target();
    set_client(1, 6, 0, 16'h1111);
    push_txn(1, 0, 1'b1);
    req = 4'b0010;
    run_txn(1, 1'b1, 5'b11111, 0, 1, 50);
    check_int("invalid_wrt_count", n_wrt, 0);
    check_int("invalid_ss_low_cycles", n_lowcyc, 0);
    check_int("invalid_gnt_cycles", n_gnt_cyc, 2);
    check_int("invalid_done_count", n_done, 1);
    check_drained("invalid");
  endtask

  task automatic test_max_len();
    set_client(3, 3, 15, 16'h0F00);
    push_txn(3, 15, 1'b0);
    rnext = 16'h8000;
    req   = 4'b1000;
    run_txn(1, 1'b1, 5'b10111, 0, 2, 400);
    check_int("maxlen_wrt_count", n_wrt, 16);
    check_int("maxlen_ack_count", n_ack, 16);
    check_int("maxlen_ss_value", ss_bad, 0);
    check_int("maxlen_done_count", n_done, 1);
    check_drained("maxlen");
  endtask

  task automatic test_reset_mid_burst();
    set_client(0, 2, 3, 16'h7700);
    push_txn(0, 3, 1'b0);
    rnext = 16'h5500;
    req   = 4'b0001;
    run_txn(1000, 1'b1, 5'b11011, 2, 1, 100);
    check_int("abort_wrt_count", n_wrt, 2);
    @(negedge clk);
    check_idle_outputs("reset_mid_burst");
    rst       = 1'b0;
    spi_done  = 1'b1;
    spi_rdata = 16'hBEEF;
    @(negedge clk);
    spi_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check_idle_outputs("spi_done_after_abort");
      @(negedge clk);
    end
    exp_cmd_q.delete();
    exp_rd_q.delete();
    exp_gnt_q.delete();
    exp_done_q.delete();
    have_cmd = 1'b0;
    prev_gnt = '0;
    // Pointer was 1 before reset; client 0 winning over client 2 shows it returned to 0.
    set_client(0, 2, 0, 16'h7700);
    set_client(2, 0, 0, 16'h2222);
    push_txn(0, 0, 1'b0);
    rnext = 16'h6600;
    req   = 4'b0101;
    run_txn(1, 1'b0, 5'b11011, 0, 1, 50);
    check_int("post_reset_done_count", n_done, 1);
    check_drained("post_reset");
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_ss    = '0;
    req_len   = '0;
    req_cmd   = '0;
    spi_done  = 1'b0;
    spi_rdata = '0;
    rnext     = '0;
    last_cmd  = '0;
    for (int i = 0; i < int'(NR); i++) begin
      base[i] = '0;
      widx[i] = 0;
    end
    test_reset();
    test_arbitration();
    test_single();
    test_burst();
    test_invalid_target();
    test_max_len();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary by 500000, want finish earlier");
    $fatal(1);
  end

endmodule

// File: doc/spi_ss_sequencer.md
SPI_SS_SEQUENCER -- requirements
Module: spi_ss_sequencer

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesting clients.
REQ-002 Parameter NUM_SS, default 5: number of SPI slaves; SSW = clog2(NUM_SS), minimum 1.
REQ-003 Parameter CMD_W, default 16: SPI word width.
REQ-004 Parameter LEN_W, default 4: burst length field width; bursts are 1..2^LEN_W words.
REQ-005 Parameter GUARD, default 2: number of cycles ss_n is held high after a burst.
REQ-006 Port clk, input, 1 bit: the single clock. All state updates on the rising edge.
REQ-007 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 req, input, NUM_REQ: per-client transaction request, level.
REQ-009 req_ss, input, NUM_REQ*SSW: per-client target slave index.
REQ-010 req_len, input, NUM_REQ*LEN_W: per-client word count minus 1.
REQ-011 req_cmd, input, NUM_REQ*CMD_W: per-client current word to send.
REQ-012 gnt, output, NUM_REQ: one-hot; high for the owning client from grant until done.
REQ-013 word_ack, output, NUM_REQ: 1-cycle pulse when the current req_cmd word is captured; the client presents its next word on the following cycle.
REQ-014 rd_data, output, CMD_W: word returned by the SPI master. rd_valid, output, 1: 1-cycle pulse qualifying rd_data.
REQ-015 done, output, NUM_REQ: 1-cycle pulse to the owner at the end of a transaction.
REQ-016 err, output, 1: 1-cycle pulse when a request targets an index >= NUM_SS.
REQ-017 spi_wrt, output, 1: start pulse to the SPI master. spi_cmd, output, CMD_W: word to the SPI master.
REQ-018 spi_done, input, 1: SPI master word-complete pulse. spi_rdata, input, CMD_W: SPI master read data.
REQ-019 ss_n, output, NUM_SS: active-low slave selects; at most one bit is low at any time.

Function
REQ-020 States: IDLE, ASSERT, SEND, WAIT, RELEASE.
REQ-021 In IDLE with any req high, the block SHALL pick a client round-robin, starting with the index after the last granted client; after reset the search starts at client 0.
REQ-022 Grant behaviour:
- gnt and the target ss_n bit go low-active/high on the edge after the request is seen in IDLE.
- The state moves to ASSERT.
- req_ss and req_len are latched at that edge.
REQ-023 ASSERT lasts 1 cycle (chip-select setup) and then moves to SEND.
REQ-024 SEND lasts 1 cycle and performs the following:
- spi_wrt = 1.
- spi_cmd is registered from the owner's req_cmd.
- word_ack pulses to the owner.
- The state moves to WAIT.
REQ-025 spi_cmd SHALL hold its value from SEND until the next SEND.
REQ-026 WAIT holds until spi_done. On spi_done:
- rd_data is latched from spi_rdata and rd_valid pulses on the next cycle.
- The remaining-word counter decrements.
- The state moves to SEND if words remain, otherwise to RELEASE.
REQ-027 ss_n stays low continuously from ASSERT through the final WAIT; it is not released between words of a burst.
REQ-028 RELEASE behaviour:
- ss_n is all high.
- The state lasts GUARD cycles.
- done pulses to the owner in the first RELEASE cycle.
- gnt clears when RELEASE exits to IDLE.
REQ-029 req is sampled only in IDLE. Dropping req mid-transaction has no effect; the burst completes.
REQ-030 spi_done outside WAIT SHALL be ignored.
REQ-031 A spi_done arriving in the same cycle as SEND cannot occur legally and SHALL be ignored.
REQ-032 If the latched req_ss >= NUM_SS:
- The block goes directly to RELEASE, skipping ASSERT.
- err and done both pulse in the first RELEASE cycle.
- No ss_n bit is asserted and spi_wrt is not issued.
REQ-033 req_len = 2^LEN_W-1 SHALL yield exactly 2^LEN_W words. The counter SHALL NOT wrap.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 With rst high at an edge, all of the following take effect, including mid-burst:
- State = IDLE, with no further spi_wrt.
- ss_n = all 1s; gnt, word_ack, done, err, rd_valid, spi_wrt = 0.
- spi_cmd = 0, rd_data = 0.
- The round-robin pointer is set to client 0.
REQ-036 An spi_done arriving during reset or immediately after it SHALL be ignored.

Verification
REQ-037 Single word: client 2, ss=1, len=0, cmd=16'hA5C3.
- ss_n=5'b11101 for 3 cycles + the spi_done wait.
- spi_wrt is 1 cycle with spi_cmd=16'hA5C3.
- spi_rdata=16'h00FF -> rd_data=16'h00FF with rd_valid, then done[2].
- ss_n returns to 5'b11111 for 2 cycles.
REQ-038 Burst: client 0, ss=4, len=2.
- Three spi_wrt pulses and three word_ack[0] pulses.
- ss_n[4] stays low throughout.
- Exactly one done[0].
REQ-039 Arbitration: req=4'b1111 held continuously.
- Grants occur in the order 0,1,2,3,0.
- gnt is never multi-hot.
REQ-040 Invalid target: client 1, ss=6.
- err and done[1] pulse.
- ss_n stays 5'b11111 and there is no spi_wrt.
REQ-041 Reset mid-burst: rst asserted in WAIT of word 2 of a len=3 burst.
- Next cycle: ss_n=5'b11111, gnt=0, IDLE.
- A following spi_done is ignored.
REQ-042 Maximum length: len=4'hF -> exactly 16 spi_wrt pulses, then done.
